// File: rtl/addsub_cplx_pipe.sv
// Pipelined complex add/subtract on packed {real, imag} signed samples, with saturation, sticky status and valid/ready.
// Build option: define ADDSUB_CPLX_HALVE_EN to halve each result (floor) instead of saturating it.
module addsub_cplx_pipe #(
    parameter int CW     = 24,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*CW-1:0]   in1,
    input  logic [2*CW-1:0]   in2,
    input  logic [1:0]        mode,
    output logic [2*CW-1:0]   op,
    output logic [1:0]        op_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done_flag,
    output logic              ovf_r,
    output logic              ovf_i,
    input  logic              clr_status,
    output logic [CNT_W-1:0]  xfer_count
);

    localparam logic [CW-1:0] MAX_VAL = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] MIN_VAL = {1'b1, {(CW-1){1'b0}}};

    logic               w_advance;
    logic               w_xfer;
    logic               w_re_sub;
    logic               w_im_sub;
    logic signed [CW:0] w_a_r, w_a_i, w_b_r, w_b_i;
    logic signed [CW:0] w_raw_r, w_raw_i;
    logic [CW-1:0]      w_res_r, w_res_i;
    logic               w_sat_r, w_sat_i;

    logic               r_valid [STAGES];
    logic [2*CW-1:0]    r_data  [STAGES];
    logic [1:0]         r_sat   [STAGES];
    logic               r_ovf_r;
    logic               r_ovf_i;
    logic [CNT_W-1:0]   r_xfer_count;

    // A full output that is not being taken stalls every stage at once.
    assign w_advance  = enable && !(out_valid && !out_ready);
    assign w_xfer     = enable && out_valid && out_ready;
    assign in_ready   = w_advance;
    assign done_flag  = w_xfer;
    assign out_valid  = r_valid[STAGES-1];
    assign op         = r_data[STAGES-1];
    assign op_sat     = r_sat[STAGES-1];
    assign ovf_r      = r_ovf_r;
    assign ovf_i      = r_ovf_i;
    assign xfer_count = r_xfer_count;

    assign w_a_r = {in1[2*CW-1], in1[2*CW-1:CW]};
    assign w_a_i = {in1[CW-1],   in1[CW-1:0]};
    assign w_b_r = {in2[2*CW-1], in2[2*CW-1:CW]};
    assign w_b_i = {in2[CW-1],   in2[CW-1:0]};

    // Real part subtracts in modes 01/11, imaginary part in modes 01/10 (conjugate of B).
    assign w_re_sub = mode[0];
    assign w_im_sub = mode[0] ^ mode[1];
    assign w_raw_r  = w_re_sub ? (w_a_r - w_b_r) : (w_a_r + w_b_r);
    assign w_raw_i  = w_im_sub ? (w_a_i - w_b_i) : (w_a_i + w_b_i);

`ifdef ADDSUB_CPLX_HALVE_EN
    logic w_unused_lsb;

    // Floor of a CW+1-bit value divided by two always fits in CW bits, so nothing clamps.
    assign w_res_r      = w_raw_r[CW:1];
    assign w_res_i      = w_raw_i[CW:1];
    assign w_sat_r      = 1'b0;
    assign w_sat_i      = 1'b0;
    assign w_unused_lsb = w_raw_r[0] ^ w_raw_i[0];
`else
    // The CW+1-bit result is out of range exactly when its top two bits disagree.
    assign w_sat_r = w_raw_r[CW] != w_raw_r[CW-1];
    assign w_sat_i = w_raw_i[CW] != w_raw_i[CW-1];
    assign w_res_r = w_sat_r ? (w_raw_r[CW] ? MIN_VAL : MAX_VAL) : w_raw_r[CW-1:0];
    assign w_res_i = w_sat_i ? (w_raw_i[CW] ? MIN_VAL : MAX_VAL) : w_raw_i[CW-1:0];
`endif

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value, making the shift order-independent.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the data stages are reset along with the valid bits because op is a
            // visible output that must read 0 after reset, not just a don't-care payload.
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_data[s]  <= '0;
                r_sat[s]   <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            r_data[0]  <= {w_res_r, w_res_i};
            r_sat[0]   <= {w_sat_r, w_sat_i};
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_data[s]  <= r_data[s-1];
                r_sat[s]   <= r_sat[s-1];
            end
        end
    end

    // Sticky flags: a set on the current transfer overrides a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf_r      <= 1'b0;
            r_ovf_i      <= 1'b0;
            r_xfer_count <= '0;
        end else if (enable) begin
            r_ovf_r <= (r_ovf_r && !clr_status) || (w_xfer && op_sat[1]);
            r_ovf_i <= (r_ovf_i && !clr_status) || (w_xfer && op_sat[0]);
            if (w_xfer) begin
                r_xfer_count <= r_xfer_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_cplx_pipe.sv
// Self-checking bench for addsub_cplx_pipe: directed test-plan cases plus randomized traffic
// scored against an in-order queue of results computed with plain integer arithmetic.
module tb_addsub_cplx_pipe;

    localparam int CW     = 24;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [1:0]      sat;
        logic [2*CW-1:0] data;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2*CW-1:0]  in1 = '0;
    logic [2*CW-1:0]  in2 = '0;
    logic [1:0]       mode = '0;
    logic [2*CW-1:0]  op;
    logic [1:0]       op_sat;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             done_flag;
    logic             ovf_r;
    logic             ovf_i;
    logic             clr_status = 1'b0;
    logic [CNT_W-1:0] xfer_count;

    addsub_cplx_pipe #(.CW(CW), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mode(mode),
        .op(op), .op_sat(op_sat), .out_valid(out_valid), .out_ready(out_ready),
        .done_flag(done_flag), .ovf_r(ovf_r), .ovf_i(ovf_i),
        .clr_status(clr_status), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    int               n_checks = 0;
    int               n_pass = 0;
    exp_t             q[$];
    logic             m_ovf_r = 1'b0;
    logic             m_ovf_i = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             hold_prev = 1'b0;
    logic [2*CW-1:0]  prev_op = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2*CW-1:0] pack(input int re, input int im);
        return {re[CW-1:0], im[CW-1:0]};
    endfunction

    function automatic int scale(input int v);
`ifdef ADDSUB_CPLX_HALVE_EN
        return v >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic exp_t model(input logic [2*CW-1:0] a, input logic [2*CW-1:0] b,
                                   input logic [1:0] m);
        longint ar, ai, br, bi, re, im, hi, lo;
        exp_t e;
        ar = longint'($signed(a[2*CW-1:CW]));
        ai = longint'($signed(a[CW-1:0]));
        br = longint'($signed(b[2*CW-1:CW]));
        bi = longint'($signed(b[CW-1:0]));
        re = (m == 2'b01 || m == 2'b11) ? ar - br : ar + br;
        im = (m == 2'b01 || m == 2'b10) ? ai - bi : ai + bi;
        hi = (longint'(1) << (CW - 1)) - 1;
        lo = -(longint'(1) << (CW - 1));
        e.sat = 2'b00;
`ifdef ADDSUB_CPLX_HALVE_EN
        re = re >>> 1;
        im = im >>> 1;
`else
        if (re > hi) begin re = hi; e.sat[1] = 1'b1; end
        else if (re < lo) begin re = lo; e.sat[1] = 1'b1; end
        if (im > hi) begin im = hi; e.sat[0] = 1'b1; end
        else if (im < lo) begin im = lo; e.sat[0] = 1'b1; end
`endif
        e.data = {re[CW-1:0], im[CW-1:0]};
        return e;
    endfunction

    function automatic logic [2*CW-1:0] rnd_word();
        logic [CW-1:0] part [2];
        for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 3))
                0:       part[k] = 24'h7FFFF0 + 24'($urandom_range(0, 15));
                1:       part[k] = 24'h800000 + 24'($urandom_range(0, 15));
                default: part[k] = 24'($urandom);
            endcase
        end
        return {part[0], part[1]};
    endfunction

    task automatic drive(input logic [2*CW-1:0] a, input logic [2*CW-1:0] b, input logic [1:0] m);
        in1 = a;
        in2 = b;
        mode = m;
        in_valid = 1'b1;
    endtask

    // One clock: score the cycle at the falling edge, then return just after the rising edge.
    task automatic step();
        exp_t e;
        logic xfer;
        @(negedge clock);
        check("ovf_r", ovf_r, m_ovf_r);
        check("ovf_i", ovf_i, m_ovf_i);
        check("xfer_count", xfer_count, m_cnt);
        xfer = enable && out_valid && out_ready;
        check("in_ready", in_ready, enable && !(out_valid && !out_ready));
        check("done_flag", done_flag, xfer);
        if (hold_prev) check("op_hold", op, prev_op);
        if (reset) begin
            q.delete();
            m_ovf_r = 1'b0;
            m_ovf_i = 1'b0;
            m_cnt = '0;
            hold_prev = 1'b0;
        end else begin
            e = '0;
            if (xfer) begin
                check("out_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("op", op, e.data);
                    check("op_sat", op_sat, e.sat);
                end
                m_cnt++;
            end
            m_ovf_r = (m_ovf_r && !(enable && clr_status)) || (xfer && e.sat[1]);
            m_ovf_i = (m_ovf_i && !(enable && clr_status)) || (xfer && e.sat[0]);
            if (in_valid && in_ready) q.push_back(model(in1, in2, mode));
            hold_prev = out_valid && !in_ready;
            prev_op = op;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        logic [CNT_W-1:0] base;

        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_op", op, 0);
        check("rst_op_sat", op_sat, 0);
        check("rst_done", done_flag, 0);
        check("rst_ovf_r", ovf_r, 0);
        check("rst_ovf_i", ovf_i, 0);
        check("rst_count", xfer_count, 0);
        reset = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;

        // Basic add and latency, then enable=0 must block the transfer.
        drive(pack(100, -50), pack(25, 10), 2'b00);
        step();
        in_valid = 1'b0;
        check("lat_early", out_valid, 0);
        step();
        check("lat_valid", out_valid, 1);
        check("basic_op", op, pack(scale(125), scale(-40)));
        enable = 1'b0;
        step();
        step();
        check("en0_valid", out_valid, 1);
        check("en0_count", xfer_count, 0);
        enable = 1'b1;
        step();
        check("basic_count", xfer_count, 1);

        // Conjugate modes back to back.
        drive(pack(3, 4), pack(1, 2), 2'b10);
        step();
        drive(pack(3, 4), pack(1, 2), 2'b11);
        step();
        check("conj10_valid", out_valid, 1);
        check("conj10_op", op, pack(scale(4), scale(2)));
        drive(pack(3, 4), pack(1, 2), 2'b01);
        step();
        in_valid = 1'b0;
        check("conj11_op", op, pack(scale(2), scale(6)));
        step();
        check("sub01_op", op, pack(scale(2), scale(2)));
        step();

`ifndef ADDSUB_CPLX_HALVE_EN
        drive(pack(32'h7FFFFF, 0), pack(1, 0), 2'b00);
        step();
        in_valid = 1'b0;
        step();
        check("sat_re", op[2*CW-1:CW], 24'h7FFFFF);
        check("sat_re_flag", op_sat, 2'b10);
        step();
        check("sat_ovf_r", ovf_r, 1);
        drive(pack(0, 32'h800000), pack(0, 1), 2'b01);
        step();
        in_valid = 1'b0;
        step();
        check("sat_im", op[CW-1:0], 24'h800000);
        check("sat_im_flag", op_sat, 2'b01);
        step();
        check("sat_ovf_i", ovf_i, 1);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        check("clr_ovf_r", ovf_r, 0);
        check("clr_ovf_i", ovf_i, 0);
`else
        drive(pack(7, -7), pack(0, 0), 2'b00);
        step();
        in_valid = 1'b0;
        step();
        check("halve_op", op, pack(3, -4));
        drive(pack(32'h7FFFFF, 0), pack(32'h7FFFFF, 0), 2'b00);
        step();
        in_valid = 1'b0;
        step();
        check("halve_max", op[2*CW-1:CW], 24'h7FFFFF);
        check("halve_sat", op_sat, 2'b00);
        step();
        check("halve_ovf_r", ovf_r, 0);
`endif

        // Backpressure: five samples, out_ready low for three cycles mid-stream.
        sent = 0;
        base = xfer_count;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid = (sent < 5);
            in1 = pack(sent * 7 + 1, -sent);
            in2 = pack(sent, 3);
            mode = sent[1:0];
            #1;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_sent", sent, 5);
        check("bp_count", xfer_count - base, 5);

        // Randomized traffic with stalls, enable gaps and status clears.
        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_status = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in1 = rnd_word();
            in2 = rnd_word();
            mode = 2'($urandom_range(0, 3));
            step();
        end
        clr_status = 1'b0;
        in_valid = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) step();
        check("drain_empty", q.size(), 0);

        // Reset with two samples in flight after a saturating transfer.
        drive(pack(32'h7FFFFF, 0), pack(5, 0), 2'b00);
        step();
        drive(pack(1, 1), pack(2, 2), 2'b00);
        step();
        drive(pack(3, 3), pack(4, 4), 2'b01);
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
`ifndef ADDSUB_CPLX_HALVE_EN
        check("pre_rst_ovf_r", ovf_r, 1);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ovf_r", ovf_r, 0);
        check("mid_rst_ovf_i", ovf_i, 0);
        check("mid_rst_count", xfer_count, 0);
        check("mid_rst_op", op, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("no_stale", out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
